// File: rtl/borrow_lookahead_sub_pipe_if.sv
// borrow_lookahead_sub_pipe_if: operand/result handshake bundle for the pipelined subtractor
interface borrow_lookahead_sub_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready, b_in;
  logic [WIDTH-1:0] a, b, diff;
  logic             out_valid, out_ready, b_out, zero, neg, ovf, lt_u, lt_s;
  modport master (output in_valid, a, b, b_in, out_ready,
                  input  in_ready, out_valid, diff, b_out, zero, neg, ovf, lt_u, lt_s);
  modport slave  (input  in_valid, a, b, b_in, out_ready,
                  output in_ready, out_valid, diff, b_out, zero, neg, ovf, lt_u, lt_s);
endinterface

// File: rtl/borrow_lookahead_sub_pipe.sv
// borrow_lookahead_sub_pipe: two-stage borrow-lookahead a - b - b_in with compare flags
module borrow_lookahead_sub_pipe #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  borrow_lookahead_sub_pipe_if.slave bus
);
  localparam int NC = WIDTH / 4;
  localparam int NB = WIDTH / 16;
  logic [WIDTH-1:0] g, p, s1_x, s1_g, s1_p, d;
  logic [NC-1:0]    cp, cg, s1_cp, s1_cg;
  logic [NB-1:0]    bp, bg;
  logic [NB:0]      bb;
  logic [NC:0]      cb;
  logic [WIDTH:0]   bw;
  logic             s1_bin, s1_am, s1_bm, s1_valid, s1_load, s2_load, ov;
  function automatic logic grp(input logic [3:0] pp, input logic [3:0] gg);
    return gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]);
  endfunction
  assign g = ~bus.a & bus.b;
  assign p = ~(bus.a ^ bus.b);
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      cp[c] = &p[4*c +: 4];
      cg[c] = grp(p[4*c +: 4], g[4*c +: 4]);
    end
  end
  // each borrow is a flat sum of products from the level above, never chained through siblings
  always_comb begin
    logic t;
    t = 1'b0;
    for (int k = 0; k < NB; k++) begin
      bp[k] = &s1_cp[4*k +: 4];
      bg[k] = grp(s1_cp[4*k +: 4], s1_cg[4*k +: 4]);
    end
    bb[0] = s1_bin;
    for (int k = 0; k < NB; k++) begin
      t = s1_bin;
      for (int j = 0; j <= k; j++) t = bg[j] | (bp[j] & t);
      bb[k+1] = t;
    end
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < 4; i++) begin
        t = bb[k];
        for (int j = 0; j < i; j++) t = s1_cg[4*k+j] | (s1_cp[4*k+j] & t);
        cb[4*k+i] = t;
      end
    cb[NC] = bb[NB];
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 4; i++) begin
        t = cb[c];
        for (int j = 0; j < i; j++) t = s1_g[4*c+j] | (s1_p[4*c+j] & t);
        bw[4*c+i] = t;
      end
    bw[WIDTH] = cb[NC];
  end
  assign d  = s1_x ^ bw[WIDTH-1:0];
  assign ov = (s1_am ^ s1_bm) & (d[WIDTH-1] ^ s1_am);
  assign s2_load = s1_valid & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = rst_n & (~s1_valid | s2_load);
  assign s1_load = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_x          <= '0;
      s1_g          <= '0;
      s1_p          <= '0;
      s1_cp         <= '0;
      s1_cg         <= '0;
      s1_bin        <= 1'b0;
      s1_am         <= 1'b0;
      s1_bm         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.diff      <= '0;
      bus.b_out     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.neg       <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.lt_u      <= 1'b0;
      bus.lt_s      <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_x   <= bus.a ^ bus.b;
        s1_g   <= g;
        s1_p   <= p;
        s1_cp  <= cp;
        s1_cg  <= cg;
        s1_bin <= bus.b_in;
        s1_am  <= bus.a[WIDTH-1];
        s1_bm  <= bus.b[WIDTH-1];
      end
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      if (s2_load) begin
        bus.diff  <= d;
        bus.b_out <= bw[WIDTH];
        bus.zero  <= ~|d;
        bus.neg   <= d[WIDTH-1];
        bus.ovf   <= ov;
        bus.lt_u  <= bw[WIDTH];
        bus.lt_s  <= d[WIDTH-1] ^ ov;
      end
      bus.out_valid <= s2_load | (bus.out_valid & ~bus.out_ready);
    end
  end
endmodule

// File: tb/tb_borrow_lookahead_sub_pipe.sv
// tb_borrow_lookahead_sub_pipe: directed vectors, backpressure/reset sequences and random scoreboard
module tb_borrow_lookahead_sub_pipe;
  localparam int W = 32;
  typedef struct packed {logic [W-1:0] diff; logic b_out, zero, neg, ovf, lt_u, lt_s;} res_t;
  typedef struct {logic [W-1:0] a, b; logic bin; res_t exp;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  borrow_lookahead_sub_pipe_if #(.WIDTH(W)) bus ();
  borrow_lookahead_sub_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, n_in = 0, n_out = 0;
  res_t q[$];
  vec_t tv[6];
  logic hold = 1'b0;
  res_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t actual();
    res_t r;
    r.diff = bus.diff; r.b_out = bus.b_out; r.zero = bus.zero; r.neg = bus.neg;
    r.ovf = bus.ovf; r.lt_u = bus.lt_u; r.lt_s = bus.lt_s;
    return r;
  endfunction

  // reference: true integer arithmetic, flags read off the mathematical result
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    res_t r;
    logic [W:0] w;
    longint sa, sb, sd, lim;
    w = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sd = sa - sb - longint'(bin);
    lim = longint'(1) <<< (W - 1);
    r.diff = w[W-1:0];
    r.b_out = w[W];
    r.zero = (r.diff == '0);
    r.neg = r.diff[W-1];
    r.ovf = (sd >= lim) || (sd < -lim);
    r.lt_u = longint'(a) < longint'(b) + longint'(bin);
    r.lt_s = sa < sb + longint'(bin);
    return r;
  endfunction

  always @(negedge clk) begin
    #3;
    if (hold) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(actual()), 64'(held));
    end
    if (!rst_n) q.delete();
    else begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.b_in));
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got diff %0h expected no result", bus.diff);
        end else chk("result", 64'(actual()), 64'(q.pop_front()));
        n_out++;
      end
    end
    hold = rst_n && bus.out_valid && !bus.out_ready;
    held = actual();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] oa[4], ob[4];
    int acc, n0, in0, out0, sent;
    bit pend;
    tv[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, {32'h0000_0002, 6'b000000}};
    tv[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, {32'hFFFF_FFFF, 6'b101011}};
    tv[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, {32'hFFFF_FFFF, 6'b101011}};
    tv[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 6'b000101}};
    tv[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 6'b101110}};
    tv[5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, {32'h0000_0000, 6'b010000}};
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_outputs", 64'(actual()), 64'd0);
    rst_n = 1'b1; #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.a = tv[i].a; bus.b = tv[i].b; bus.b_in = tv[i].bin; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1 chk("vec_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk("vec_lat1", 64'(bus.out_valid), 64'd0);
      @(negedge clk); #1;
      chk("vec_out_valid", 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d", i), 64'(actual()), 64'(tv[i].exp));
    end
    for (int i = 0; i < 4; i++) begin oa[i] = $urandom; ob[i] = $urandom; end
    @(negedge clk);
    bus.out_ready = 1'b0; bus.b_in = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1; bus.a = oa[acc]; bus.b = ob[acc];
      #1 if (bus.in_ready) acc++;
      @(negedge clk);
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    bus.a = oa[acc]; bus.b = ob[acc];
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_frozen", 64'(actual()), 64'(model(oa[0], ob[0], 1'b0)));
    @(negedge clk);
    n0 = n_out;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = (acc < 4);
      if (acc < 4) begin bus.a = oa[acc]; bus.b = ob[acc]; end
      #1 chk("bp_stream_valid", 64'(bus.out_valid), 64'd1);
      if (bus.in_valid && bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #5;
    chk("bp_all_in", 64'(acc), 64'd4);
    chk("bp_out_count", 64'(n_out - n0), 64'd4);
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h0000_1111;
    @(negedge clk);
    bus.a = 32'h0000_0001; bus.b = 32'h0000_0002;
    @(negedge clk);
    bus.a = 32'hFFFF_0000;
    #1 chk("rm_full", 64'(bus.in_ready), 64'd0);
    n0 = n_out;
    rst_n = 1'b0;
    #1 chk("rm_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    #1;
    chk("rm_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rm_outputs", 64'(actual()), 64'd0);
    chk("rm_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (4) @(negedge clk);
    #5 chk("rm_no_stale", 64'(n_out), 64'(n0));
    in0 = n_in; out0 = n_out; sent = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        bus.a = $urandom;
        bus.b = ($urandom_range(0, 7) == 0) ? bus.a : W'($urandom);
        bus.b_in = 1'($urandom_range(0, 1));
      end
      bus.in_valid = pend;
      #1 if (pend && bus.in_ready) begin pend = 1'b0; sent++; end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #5;
    chk("rand_sent", 64'(sent), 64'd10000);
    chk("rand_drained", 64'(q.size()), 64'd0);
    chk("rand_count", 64'(n_out - out0), 64'(n_in - in0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
